// File: rtl/uart_fifo_bridge.sv
// Host-side bridge to the uart core: a TX FIFO feeding the core's transmit
// handshake and an RX FIFO capturing received bytes, plus overflow/error status.
module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_wr_valid,
    input  logic [7:0]            tx_wr_data,
    output logic                  tx_wr_ready,
    output logic                  rx_rd_valid,
    output logic [7:0]            rx_rd_data,
    input  logic                  rx_rd_ready,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting,
    input  logic                  uart_received,
    input  logic [7:0]            uart_rx_byte,
    input  logic                  uart_recv_error,
    input  logic                  clr_status,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic                  rx_overflow,
    output logic [7:0]            rx_err_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    // Pointer XOR pattern that marks a full FIFO: MSBs differ, low bits equal.
    localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_START,
        TX_WAIT_DONE
    } tx_state_t;

    tx_state_t tx_state, tx_state_next;

    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, tx_wr_next, tx_rd_next;
    logic          tx_full_c, tx_empty_c, tx_push_c, tx_pop_c, tx_avail;

    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, rx_wr_next, rx_rd_next;
    logic          rx_full_c, rx_push_c, rx_pop_c;
    logic [7:0]    rx_head_c;

    assign tx_full_c  = (tx_wr_ptr ^ tx_rd_ptr) == FULL_XOR;
    assign tx_empty_c = tx_wr_ptr == tx_rd_ptr;
    assign tx_push_c  = tx_wr_valid && !tx_full_c;
    assign tx_wr_next = tx_wr_ptr + PW'(tx_push_c);
    assign tx_rd_next = tx_rd_ptr + PW'(tx_pop_c);

    always_ff @(posedge clk) begin
        if (tx_push_c) begin
            tx_mem[tx_wr_ptr[DEPTH_LOG2-1:0]] <= tx_wr_data;
        end
    end

    // tx_avail lags occupancy by a cycle so a fresh byte is seen one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_level    <= '0;
            tx_wr_ready <= 1'b1;
            tx_avail    <= 1'b0;
        end else begin
            tx_wr_ptr   <= tx_wr_next;
            tx_rd_ptr   <= tx_rd_next;
            tx_level    <= tx_wr_next - tx_rd_next;
            tx_wr_ready <= (tx_wr_next ^ tx_rd_next) != FULL_XOR;
            tx_avail    <= !tx_empty_c;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_pop_c      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_avail && !tx_empty_c && !uart_is_transmitting) begin
                    tx_pop_c      = 1'b1;
                    tx_state_next = TX_WAIT_START;
                end
            end
            TX_WAIT_START: begin
                if (uart_is_transmitting) begin
                    tx_state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state      <= TX_IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            tx_state      <= tx_state_next;
            uart_transmit <= tx_pop_c;
            if (tx_pop_c) begin
                uart_tx_byte <= tx_mem[tx_rd_ptr[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
    assign rx_full_c  = (rx_wr_ptr ^ rx_rd_ptr) == FULL_XOR;
    assign rx_push_c  = uart_received && !rx_full_c;
    assign rx_pop_c   = rx_rd_valid && rx_rd_ready;
    assign rx_wr_next = rx_wr_ptr + PW'(rx_push_c);
    assign rx_rd_next = rx_rd_ptr + PW'(rx_pop_c);
    assign rx_head_c  = (rx_push_c && (rx_rd_next == rx_wr_ptr)) ? uart_rx_byte
                                                                 : rx_mem[rx_rd_next[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push_c) begin
            rx_mem[rx_wr_ptr[DEPTH_LOG2-1:0]] <= uart_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_level    <= '0;
            rx_rd_valid <= 1'b0;
            rx_rd_data  <= 8'h00;
        end else begin
            rx_wr_ptr   <= rx_wr_next;
            rx_rd_ptr   <= rx_rd_next;
            rx_level    <= rx_wr_next - rx_rd_next;
            rx_rd_valid <= rx_wr_next != rx_rd_next;
            if (rx_wr_next != rx_rd_next) begin
                rx_rd_data <= rx_head_c;
            end
        end
    end

    // Status: a same-cycle event takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow  <= 1'b0;
            rx_err_count <= 8'h00;
        end else begin
            if (uart_received && rx_full_c) begin
                rx_overflow <= 1'b1;
            end else if (clr_status) begin
                rx_overflow <= 1'b0;
            end
            if (clr_status) begin
                rx_err_count <= uart_recv_error ? 8'd1 : 8'd0;
            end else if (uart_recv_error && (rx_err_count != 8'hFF)) begin
                rx_err_count <= rx_err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Host-side companion to the uart core. It buffers outbound bytes in a TX FIFO and feeds them one at a time into the core's transmit/tx_byte handshake.
- It captures each received/rx_byte pulse from the core into an RX FIFO, and exposes valid/ready byte streams plus overflow and error status to the rest of the design.
- It sits between the uart core and any byte producer/consumer, such as a command parser.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (depth = 16 entries at default); applies to TX and RX alike.

Ports:
- clk  in  1  master clock, shared with the uart core
- rst_n  in  1  asynchronous active-low reset
- tx_wr_valid  in  1  host offers a byte for transmission
- tx_wr_data  in  8  byte to transmit
- tx_wr_ready  out  1  TX FIFO not full
- rx_rd_valid  out  1  RX FIFO not empty
- rx_rd_data  out  8  head byte of RX FIFO (first-word fall-through)
- rx_rd_ready  in  1  host consumes head byte
- uart_transmit  out  1  one-cycle start pulse to uart core
- uart_tx_byte  out  8  byte presented to uart core, registered
- uart_is_transmitting  in  1  uart core busy flag
- uart_received  in  1  one-cycle byte-received strobe from uart core
- uart_rx_byte  in  8  received byte from uart core
- uart_recv_error  in  1  one-cycle receive-error strobe from uart core
- clr_status  in  1  synchronous clear of rx_overflow and rx_err_count
- tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy
- rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy
- rx_overflow  out  1  sticky: received byte dropped because RX FIFO full
- rx_err_count  out  8  saturating count of uart_recv_error strobes

Behaviour:
- Reset (rst_n low, asynchronous):
  - both FIFOs empty; levels 0; tx_wr_ready=1; rx_rd_valid=0.
  - rx_rd_data=0, uart_transmit=0, uart_tx_byte=0, rx_overflow=0, rx_err_count=0.
  - sequencer in TX_IDLE.
  - Reset mid-transmission abandons queued bytes; the uart core is not reset by this block, so a byte already handed over completes on the line.
- FIFOs:
  - circular buffers with DEPTH_LOG2+1-bit read/write pointers; full when the pointer MSBs differ and the low bits are equal.
  - a write when full or a read when empty has no effect.
  - a simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
  - a push on an empty FIFO makes data visible the next cycle; there is no same-cycle bypass.
- TX write: a byte is accepted on a clk edge with tx_wr_valid && tx_wr_ready.
- TX sequencer states: TX_IDLE, TX_WAIT_START, TX_WAIT_DONE.
  - TX_IDLE: if TX FIFO non-empty && !uart_is_transmitting, pop the head into uart_tx_byte, assert uart_transmit for exactly one cycle, and go to TX_WAIT_START.
  - TX_WAIT_START: wait for uart_is_transmitting=1 (the core raises it the cycle after sampling transmit), then go to TX_WAIT_DONE. uart_transmit is 0 here.
  - TX_WAIT_DONE: wait for uart_is_transmitting=0 (this includes the core's 2-stop-bit delay), then go to TX_IDLE.
  - Latency: from a write into an empty FIFO with an idle core, uart_transmit pulses 2 cycles after the write edge.
  - Back-to-back bytes: the next pulse comes no earlier than 1 cycle after is_transmitting falls.
  - uart_tx_byte holds its value until the next pop.
- RX capture:
  - on uart_received=1, push uart_rx_byte if the RX FIFO is not full.
  - if full, drop the byte and set rx_overflow; the FIFO contents are unchanged.
  - a pop (rx_rd_valid && rx_rd_ready) in the same cycle as a push while full still counts as full, so the byte is dropped. This is the decided, simple rule.
- Error count:
  - uart_recv_error increments rx_err_count, saturating at 255.
  - clr_status zeroes rx_overflow and rx_err_count; an event in the same cycle as the clear wins (overflow reads 1, count reads 1).
- rx_rd_data always shows the FIFO head; its value is undefined-but-stable when empty (holds the last value).
- Levels are updated registered, one cycle after the accepting edge.

Test Plan:
- Reset, write 0x55, 0xA3, 0x0F with an idle core model (is_transmitting high for 40 cycles after each pulse) -> three uart_transmit pulses, uart_tx_byte 0x55, 0xA3, 0x0F in order; first pulse 2 cycles after the write; tx_level returns to 0.
- Write 17 bytes with the core held busy, DEPTH_LOG2=4 -> tx_wr_ready drops after 16 and the 17th is ignored; tx_level=16; after release, exactly 16 pulses.
- Drive 16 uart_received strobes with bytes 0x00..0x0F, host not ready, then a 17th with 0xFF -> rx_level=16, rx_overflow=1; draining yields 0x00..0x0F, never 0xFF.
- Push and pop the RX FIFO simultaneously at level 5 -> level stays 5 and data order is preserved; at level 16 a received byte is dropped and rx_overflow is set.
- Apply 300 uart_recv_error strobes -> rx_err_count=255; clr_status with a simultaneous strobe -> count=1.
- Assert rst_n low while in TX_WAIT_DONE with 4 bytes queued -> immediately tx_level=0, uart_transmit=0; after release, no further pulses.
